// File: rtl/song_sequencer.sv
// song_sequencer: one play-through of a song chart, beat-timed countdown,
// one chart entry per beat, results hold, then a one-cycle done to the menu.
module song_sequencer #(
    parameter int unsigned TICKS_PER_BEAT  = 1625000,
    parameter int unsigned COUNTDOWN_BEATS = 3,
    parameter int unsigned RESULT_BEATS    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] song,
    input  logic       abort,
    input  logic       pause,
    output logic [9:0] chart_addr,
    input  logic [7:0] chart_data,
    output logic [7:0] note,
    output logic       note_valid,
    output logic [1:0] countdown,
    output logic [2:0] phase,
    output logic       busy,
    output logic       done
);

    localparam int unsigned TIMER_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam int unsigned RES_W   = (RESULT_BEATS > 1) ? $clog2(RESULT_BEATS + 1) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TICKS_PER_BEAT - 1);
    localparam logic [RES_W-1:0]   RES_LAST   = RES_W'(RESULT_BEATS - 1);
    localparam logic [7:0]         END_MARK   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_FETCH     = 3'd2,
        ST_LATCH     = 3'd3,
        ST_PLAY      = 3'd4,
        ST_RESULTS   = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [RES_W-1:0]   res_cnt_q, res_cnt_d;
    logic [7:0]         idx_q, idx_d;
    logic [1:0]         song_q, song_d;
    logic [9:0]         chart_addr_q, chart_addr_d;
    logic [7:0]         note_q, note_d;
    logic               note_valid_q, note_valid_d;
    logic [1:0]         countdown_q, countdown_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               timer_hold;
    logic               beat_tick;
    logic [1:0]         song_sel;
    logic [7:0]         idx_inc;

    // Song 3 has no chart region of its own and aliases song 2
    assign song_sel = (song == 2'd3) ? 2'd2 : song;
    assign idx_inc  = idx_q + 8'd1;

    // Beat timer: frozen by pause only while counting down or playing
    always_comb begin
        timer_hold = pause && ((state_q == ST_COUNTDOWN) || (state_q == ST_PLAY));
        beat_tick  = (state_q != ST_IDLE) && !timer_hold && (timer_q == TIMER_LAST);
        timer_d    = timer_q;
        if (state_q == ST_IDLE) begin
            timer_d = '0;
        end else if (!timer_hold) begin
            timer_d = beat_tick ? '0 : timer_q + TIMER_W'(1);
        end
    end

    // Next-state and registered-output logic; abort overrides everything
    always_comb begin
        state_d      = state_q;
        res_cnt_d    = res_cnt_q;
        idx_d        = idx_q;
        song_d       = song_q;
        chart_addr_d = chart_addr_q;
        note_d       = note_q;
        note_valid_d = 1'b0;
        countdown_d  = countdown_q;
        done_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A start coinciding with the outgoing done pulse is dropped
                if (start && !done_q) begin
                    song_d       = song_sel;
                    idx_d        = 8'd0;
                    chart_addr_d = {song_sel, 8'd0};
                    countdown_d  = 2'(COUNTDOWN_BEATS);
                    state_d      = ST_COUNTDOWN;
                end
            end
            ST_COUNTDOWN: begin
                if (beat_tick) begin
                    if (countdown_q == 2'd1) begin
                        countdown_d = 2'd0;
                        state_d     = ST_FETCH;
                    end else begin
                        countdown_d = countdown_q - 2'd1;
                    end
                end
            end
            ST_FETCH: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (chart_data == END_MARK) begin
                    res_cnt_d = '0;
                    state_d   = ST_RESULTS;
                end else begin
                    note_d       = chart_data;
                    note_valid_d = 1'b1;
                    state_d      = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (beat_tick) begin
                    // Chart region is 256 entries; never step into the next song
                    if (idx_q == 8'hFF) begin
                        res_cnt_d = '0;
                        state_d   = ST_RESULTS;
                    end else begin
                        idx_d        = idx_inc;
                        chart_addr_d = {song_q, idx_inc};
                        state_d      = ST_FETCH;
                    end
                end
            end
            ST_RESULTS: begin
                if (beat_tick) begin
                    if (res_cnt_q == RES_LAST) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        res_cnt_d = res_cnt_q + RES_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d      = ST_IDLE;
            res_cnt_d    = res_cnt_q;
            idx_d        = idx_q;
            song_d       = song_q;
            chart_addr_d = chart_addr_q;
            note_d       = note_q;
            note_valid_d = 1'b0;
            countdown_d  = 2'd0;
            done_d       = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            res_cnt_q    <= '0;
            idx_q        <= 8'd0;
            song_q       <= 2'd0;
            chart_addr_q <= 10'd0;
            note_q       <= 8'd0;
            note_valid_q <= 1'b0;
            countdown_q  <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            res_cnt_q    <= res_cnt_d;
            idx_q        <= idx_d;
            song_q       <= song_d;
            chart_addr_q <= chart_addr_d;
            note_q       <= note_d;
            note_valid_q <= note_valid_d;
            countdown_q  <= countdown_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign chart_addr = chart_addr_q;
    assign note       = note_q;
    assign note_valid = note_valid_q;
    assign countdown  = countdown_q;
    assign phase      = state_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
